// File: rtl/rr_arbiter16_low_en_pkg.sv
// rr_arbiter16_low_en_pkg: shared types and sizes for the 16-way decoder arbiter
package rr_arbiter16_low_en_pkg;
    localparam int N_REQ = 16;
    localparam int IDX_W = 4;
    localparam int CNT_W = 8;
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
endpackage

// File: rtl/rr_pick16.sv
// rr_pick16: first set request bit after ptr, searching upward with wrap
module rr_pick16
    import rr_arbiter16_low_en_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);
    logic             found;
    logic [IDX_W-1:0] j;
    // k=1 checks ptr+1 first; k=N_REQ wraps back onto ptr itself as lowest priority
    always_comb begin
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = ptr + IDX_W'(k);
            if (!found && req[j]) begin
                idx   = j;
                found = 1'b1;
            end
        end
        any = |req;
    end
endmodule

// File: rtl/rr_arbiter16_low_en.sv
// rr_arbiter16_low_en: round-robin owner of a shared active-low-enable 4-to-16 decoder
module rr_arbiter16_low_en
    import rr_arbiter16_low_en_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic             dec_e,
    output logic [IDX_W-1:0] dec_w,
    output logic             gnt_valid,
    output logic             preempt
);
    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;

    rr_pick16 u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // FSM with registered decoder drive; release wins over expiry so preempt only flags forced ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dec_e     <= 1'b1;
            dec_w     <= '0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
            ptr       <= IDX_W'(N_REQ - 1);
            cnt       <= '0;
        end else begin
            case (state)
                IDLE, GAP: begin
                    preempt <= 1'b0;
                    if (pick_any) begin
                        state     <= GRANT;
                        dec_w     <= pick_idx;
                        dec_e     <= 1'b0;
                        gnt_valid <= 1'b1;
                        cnt       <= CNT_W'(1);
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (!req[dec_w] || cnt == CNT_W'(HOLD_MAX)) begin
                        state     <= GAP;
                        ptr       <= dec_w;
                        dec_e     <= 1'b1;
                        gnt_valid <= 1'b0;
                        preempt   <= req[dec_w];
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rr_arbiter16_low_en.sv
// tb_rr_arbiter16_low_en: scenario tasks checking two arbiter instances against hand-derived grant sequences
module tb_rr_arbiter16_low_en;
    logic        clk;
    logic        rst_n;
    logic [15:0] req4, req3;
    logic        e4, v4, p4, e3, v3, p3;
    logic [3:0]  w4, w3;
    logic [6:0]  sb[$];
    logic [6:0]  got, want;
    int          checks = 0;
    int          errors = 0;

    rr_arbiter16_low_en #(.HOLD_MAX(4)) u4 (
        .clk(clk), .rst_n(rst_n), .req(req4),
        .dec_e(e4), .dec_w(w4), .gnt_valid(v4), .preempt(p4)
    );
    rr_arbiter16_low_en #(.HOLD_MAX(3)) u3 (
        .clk(clk), .rst_n(rst_n), .req(req3),
        .dec_e(e3), .dec_w(w3), .gnt_valid(v3), .preempt(p3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] mk(input logic e, input logic [3:0] w, input logic p);
        return {e, w, ~e, p};
    endfunction

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [15:0] rq [0:2];
        logic [6:0]  ex [0:2];
        rst_n = 1'b0;
        req4  = 16'h0000;
        req3  = 16'h0000;
        sb.push_back(mk(1'b1, 4'd0, 1'b0));
        @(posedge clk); @(posedge clk); #1;
        got = {e4, w4, v4, p4}; want = sb.pop_front(); checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_values {e,w,v,p} got %b want %b", got, want);
        end
        rst_n = 1'b1;
        rq = '{16'h0001, 16'h0000, 16'h0000};
        ex = '{mk(1'b0, 4'd0, 1'b0), mk(1'b1, 4'd0, 1'b0), mk(1'b1, 4'd0, 1'b0)};
        for (int i = 0; i < 3; i++) begin
            req4 = rq[i];
            sb.push_back(ex[i]);
            @(posedge clk); #1;
            got = {e4, w4, v4, p4}; want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL first_grant[%0d] {e,w,v,p} got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_rotation();
        logic [15:0] rq [0:14];
        logic [6:0]  ex [0:14];
        pulse_reset();
        rq = '{16'h8421, 16'h8421, 16'h8420, 16'h8420, 16'h8420, 16'h8400, 16'h8400, 16'h8400,
               16'h8000, 16'h8000, 16'h8000, 16'h0001, 16'h0001, 16'h0000, 16'h0000};
        ex = '{mk(0, 0, 0), mk(0, 0, 0), mk(1, 0, 0), mk(0, 5, 0), mk(0, 5, 0), mk(1, 5, 0),
               mk(0, 10, 0), mk(0, 10, 0), mk(1, 10, 0), mk(0, 15, 0), mk(0, 15, 0), mk(1, 15, 0),
               mk(0, 0, 0), mk(1, 0, 0), mk(1, 0, 0)};
        for (int i = 0; i < 15; i++) begin
            req4 = rq[i];
            sb.push_back(ex[i]);
            @(posedge clk); #1;
            got = {e4, w4, v4, p4}; want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL rotation[%0d] {e,w,v,p} got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_preempt();
        logic [15:0] rq [0:12];
        logic [6:0]  ex [0:12];
        pulse_reset();
        rq = '{16'h0003, 16'h0003, 16'h0003, 16'h0003, 16'h0003, 16'h0003, 16'h0003,
               16'h0003, 16'h0003, 16'h0003, 16'h0003, 16'h0000, 16'h0000};
        ex = '{mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, 0), mk(1, 0, 1),
               mk(0, 1, 0), mk(0, 1, 0), mk(0, 1, 0), mk(0, 1, 0), mk(1, 1, 1),
               mk(0, 0, 0), mk(1, 0, 0), mk(1, 0, 0)};
        for (int i = 0; i < 13; i++) begin
            req4 = rq[i];
            sb.push_back(ex[i]);
            @(posedge clk); #1;
            got = {e4, w4, v4, p4}; want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL preempt[%0d] {e,w,v,p} got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] rq [0:5];
        logic [6:0]  ex [0:5];
        rq = '{16'h4000, 16'h4001, 16'h0001, 16'h4001, 16'h0000, 16'h0000};
        ex = '{mk(0, 14, 0), mk(0, 14, 0), mk(1, 14, 0), mk(0, 0, 0), mk(1, 0, 0), mk(1, 0, 0)};
        for (int i = 0; i < 6; i++) begin
            req4 = rq[i];
            sb.push_back(ex[i]);
            @(posedge clk); #1;
            got = {e4, w4, v4, p4}; want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL wrap[%0d] {e,w,v,p} got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_release_at_expiry();
        logic [15:0] rq [0:4];
        logic [6:0]  ex [0:4];
        rq = '{16'h0004, 16'h0004, 16'h0004, 16'h0000, 16'h0000};
        ex = '{mk(0, 2, 0), mk(0, 2, 0), mk(0, 2, 0), mk(1, 2, 0), mk(1, 2, 0)};
        for (int i = 0; i < 5; i++) begin
            req3 = rq[i];
            sb.push_back(ex[i]);
            @(posedge clk); #1;
            got = {e3, w3, v3, p3}; want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL release_at_expiry[%0d] {e,w,v,p} got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] rq [0:3];
        logic [6:0]  ex [0:3];
        rq = '{16'h0080, 16'h0080, 16'h0000, 16'h0000};
        ex = '{mk(0, 7, 0), mk(0, 7, 0), mk(1, 7, 0), mk(1, 7, 0)};
        req4 = rq[0];
        sb.push_back(ex[0]);
        @(posedge clk); #1;
        got = {e4, w4, v4, p4}; want = sb.pop_front(); checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL async_setup {e,w,v,p} got %b want %b", got, want);
        end
        #2;
        rst_n = 1'b0;
        sb.push_back(mk(1, 0, 0));
        #1;
        got = {e4, w4, v4, p4}; want = sb.pop_front(); checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL async_reset_midgrant {e,w,v,p} got %b want %b", got, want);
        end
        #1;
        rst_n = 1'b1;
        for (int i = 1; i < 4; i++) begin
            req4 = rq[i];
            sb.push_back(ex[i]);
            @(posedge clk); #1;
            got = {e4, w4, v4, p4}; want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL after_reset[%0d] {e,w,v,p} got %b want %b", i, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_preempt();
        test_wrap();
        test_release_at_expiry();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
